// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI register-file slave.
// FSM states, field widths and address stepping.
package spi_regfile_pkg;

  localparam int BYTE_W       = 8;
  localparam int ADDR_FIELD_W = 7;
  localparam int CMD_RD_BIT   = 7;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WR_DATA,
    RD_DATA
  } state_e;

  function automatic logic [ADDR_FIELD_W-1:0] next_addr(
    input logic [ADDR_FIELD_W-1:0] a,
    input logic [7:0]              n,
    input bit                      inc
  );
    if (!inc) return a;
    if ({1'b0, a} == n - 8'd1) return '0;
    return a + 7'd1;
  endfunction

endpackage

// File: rtl/spi_regfile_slave_sync_edge.sv
// Two-flop synchroniser with rise/fall detection.
// Edges appear three clk after the pin changes.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[0], d_i};
      prev_q <= sync_q[1];
    end
  end

  assign lvl_o  = sync_q[1];
  assign rise_o = sync_q[1] & ~prev_q;
  assign fall_o = ~sync_q[1] & prev_q;

endmodule

// File: rtl/spi_regfile_slave.sv
// SPI mode-1 slave exposing a byte-wide register bank.
// Burst access, read-only status slots and per-register write pulses.
module spi_regfile_slave
  import spi_regfile_pkg::*;
#(
  parameter int                         NUM_REGS  = 4,
  parameter logic [NUM_REGS*BYTE_W-1:0] RESET_VAL = 32'h0302_0196,
  parameter logic [NUM_REGS-1:0]        RO_MASK   = '0,
  parameter bit                         AUTO_INC  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         mosi,
  input  logic                         cs_n,
  output logic                         miso,
  output logic                         miso_oe,
  input  logic [NUM_REGS*BYTE_W-1:0]   status_i,
  output logic [NUM_REGS*BYTE_W-1:0]   regs_o,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int         RW    = NUM_REGS * BYTE_W;
  localparam logic [7:0] NREGS = 8'(NUM_REGS);

  logic sclk_rise, sclk_fall, sclk_lvl;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic unused_edges;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk_i(clk), .rst_ni(rst_n), .d_i(sclk),
    .lvl_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk_i(clk), .rst_ni(rst_n), .d_i(mosi),
    .lvl_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk_i(clk), .rst_ni(rst_n), .d_i(cs_n),
    .lvl_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  assign unused_edges = ^{sclk_lvl, mosi_rise, mosi_fall, cs_rise};

  state_e                  state_q, state_d;
  logic [2:0]              bitcnt_q, bitcnt_d;
  logic [6:0]              shin_q, shin_d;
  logic [ADDR_FIELD_W-1:0] addr_q, addr_d;
  logic [BYTE_W-1:0]       sout_q, sout_d;
  logic                    miso_q, miso_d;
  logic [RW-1:0]           regs_q, regs_d;
  logic [NUM_REGS-1:0]     pulse_q, pulse_d;
  logic [1:0]              prime_q, prime_d;
  logic                    armed_q, armed_d;
  logic [BYTE_W-1:0]       shifted;
  logic [ADDR_FIELD_W-1:0] nxt;

  assign shifted = {shin_q, mosi_lvl};
  assign nxt     = next_addr(addr_q, NREGS, AUTO_INC);

  function automatic logic [BYTE_W-1:0] rd_byte(
    input logic [ADDR_FIELD_W-1:0] a
  );
    logic [RW-1:0]       rsh;
    logic [RW-1:0]       ssh;
    logic [NUM_REGS-1:0] msh;
    rsh = regs_q >> {a, 3'b000};
    ssh = status_i >> {a, 3'b000};
    msh = RO_MASK >> a;
    if ({1'b0, a} >= NREGS) return '0;
    return msh[0] ? ssh[BYTE_W-1:0] : rsh[BYTE_W-1:0];
  endfunction

  function automatic logic writable(
    input logic [ADDR_FIELD_W-1:0] a
  );
    logic [NUM_REGS-1:0] msh;
    msh = RO_MASK >> a;
    return ({1'b0, a} < NREGS) && !msh[0];
  endfunction

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shin_d   = shin_q;
    addr_d   = addr_q;
    sout_d   = sout_q;
    miso_d   = miso_q;
    regs_d   = regs_q;
    pulse_d  = '0;
    prime_d  = {prime_q[0], 1'b1};
    // A frame may only start once cs_n has been observed high after reset
    armed_d  = armed_q | (prime_q[1] & cs_lvl);
    if (cs_lvl) begin
      state_d  = IDLE;
      bitcnt_d = '0;
      miso_d   = 1'b0;
    end else if (cs_fall && armed_q) begin
      state_d  = CMD;
      bitcnt_d = '0;
    end else if (state_q != IDLE) begin
      if (sclk_rise && state_q == RD_DATA) begin
        miso_d = sout_q[BYTE_W-1];
        sout_d = {sout_q[BYTE_W-2:0], 1'b0};
      end
      if (sclk_fall) begin
        shin_d   = shifted[6:0];
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          unique case (state_q)
            CMD: begin
              addr_d = shifted[ADDR_FIELD_W-1:0];
              if (shifted[CMD_RD_BIT]) begin
                state_d = RD_DATA;
                sout_d  = rd_byte(shifted[ADDR_FIELD_W-1:0]);
              end else begin
                state_d = WR_DATA;
              end
            end
            WR_DATA: begin
              if (writable(addr_q)) begin
                regs_d  = (regs_q & ~(RW'(8'hFF) << {addr_q, 3'b000}))
                        | (RW'(shifted) << {addr_q, 3'b000});
                pulse_d = NUM_REGS'(1'b1) << addr_q;
              end
              addr_d = nxt;
            end
            RD_DATA: begin
              addr_d = nxt;
              sout_d = rd_byte(nxt);
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shin_q   <= '0;
      addr_q   <= '0;
      sout_q   <= '0;
      miso_q   <= 1'b0;
      regs_q   <= RESET_VAL;
      pulse_q  <= '0;
      prime_q  <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shin_q   <= shin_d;
      addr_q   <= addr_d;
      sout_q   <= sout_d;
      miso_q   <= miso_d;
      regs_q   <= regs_d;
      pulse_q  <= pulse_d;
      prime_q  <= prime_d;
      armed_q  <= armed_d;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign regs_o[i*BYTE_W +: BYTE_W] =
      RO_MASK[i] ? '0 : regs_q[i*BYTE_W +: BYTE_W];
  end

  assign miso     = miso_q;
  assign miso_oe  = ~cs_lvl & (state_q == RD_DATA);
  assign wr_pulse = pulse_q;

endmodule

// File: doc/spi_regfile_slave.md
Name: spi_regfile_slave

Overview:
Parametrised SPI slave giving an external master read/write access to a bank of byte-wide control registers. It is the successor of the first-generation SPI test slave. All logic runs in the system clock domain: SCLK, MOSI and CS_N are synchronised and edge-detected. It adds a configurable register count, per-register reset values, read-only status registers, multi-byte burst access with address auto-increment, and per-register write pulses for the downstream PWM and control logic.

Parameters:
NUM_REGS, 4, number of byte registers (1..128); address field is 7 bits.
RESET_VAL, {8'h03,8'h02,8'h01,8'h96}, flat NUM_REGS*8 reset image; byte i resets reg i.
RO_MASK, 0, bit i set -> reg i is read-only; it reads status_i byte i and SPI writes to it are ignored.
AUTO_INC, 1, 1 = address increments after each data byte in a frame; 0 = address held.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sclk  in  1  SPI clock, mode 1 (CPOL=0, CPHA=1), asynchronous to clk
mosi  in  1  SPI data in, sampled on SCLK falling edge
cs_n  in  1  SPI chip select, active low
miso  out  1  SPI data out, updated on SCLK rising edge
miso_oe  out  1  high while cs_n (synchronised) is low and state is RD_DATA
status_i  in  NUM_REGS*8  read-only register sources; a byte is used only where RO_MASK is set
regs_o  out  NUM_REGS*8  current contents of the writable registers; RO slots output 0
wr_pulse  out  NUM_REGS  one-clk pulse on the register written

Behaviour:
- Reset: async assert. State IDLE; regs = RESET_VAL; miso=0, miso_oe=0, wr_pulse=0; synchronisers cleared to sclk=0, mosi=0, cs_n=1.
- Input path: 2-flop synchroniser on each input, plus one edge-detect flop. An SCLK edge is seen 3 clk after the pin edge. Required: SCLK high and low times each >= 4 clk periods.
- Frame: cs_n falling edge -> CMD, bit counter = 0. cs_n high at any time -> IDLE; partial byte discarded, no write, miso=0.
- CMD: shift mosi in MSB-first on each SCLK fall. On the 8th fall, cmd[7]=1 -> RD_DATA, cmd[7]=0 -> WR_DATA. addr = cmd[6:0].
- WR_DATA: shift 8 bits. On the 8th fall, if addr < NUM_REGS and RO_MASK[addr]=0, the register is written the next clk and wr_pulse[addr] pulses for 1 clk. Otherwise no write and no pulse. Then the address advances and the state stays in WR_DATA for the next byte.
- RD_DATA: on entry (8th fall of the previous byte), load the shift-out register with the read byte:
  - RO_MASK[addr]=1 -> status_i byte.
  - addr >= NUM_REGS -> 8'h00.
  - otherwise -> reg value.
  The shift-out register loads in the same clk as the fall is detected. Each SCLK rise drives miso with the current MSB, then shifts. After the 8th fall the next byte is loaded (address advanced) and the state stays in RD_DATA.
- Address advance: AUTO_INC=1 -> addr+1, wrapping from NUM_REGS-1 to 0. AUTO_INC=0 -> unchanged.
- A read of a register written earlier in the same frame returns the new value.
- Reset mid-frame: the block returns to IDLE. A fresh cs_n falling edge is required, so a frame already in progress when reset releases is ignored until cs_n has been seen high.
- Simultaneous cs_n rise and the 8th SCLK fall in the same clk: cs_n wins, so no write occurs.

Decomposition:
- Package spi_regfile_pkg holds:
  - state enum IDLE/CMD/WR_DATA/RD_DATA
  - BYTE_W=8, ADDR_FIELD_W=7
  - CMD_RD_BIT=7
- Sub-module spi_sync_edge: 2-flop synchroniser plus rise/fall detect, instantiated for sclk, mosi and cs_n. The mosi instance uses level output only.

Test Plan:
- Reset defaults: after reset, read burst from addr 0, 4 bytes (cmd 8'h80) -> miso 96,01,02,03. regs_o = 32'h03020196.
- Single write: cmd 8'h02, data 8'hA5 -> regs_o byte 2 = A5. wr_pulse=4'b0100 for exactly 1 clk. Read of addr 2 returns A5.
- Burst wrap: AUTO_INC=1, cmd 8'h03, data 11,22,33 -> reg3=11, reg0=22, reg1=33. wr_pulse fires 3 times in order 3, 0, 1.
- Read-only and range: RO_MASK=4'b0010 with status_i byte1 = 5A.
  - Write 8'hFF to addr 1 -> no pulse; read of addr 1 returns 5A.
  - Write to addr 8'h10 -> no pulse; read of addr 8'h10 returns 00.
- Aborted frame: cmd 8'h01, then 5 data bits, then cs_n high -> reg1 unchanged, no pulse, miso_oe=0.
- Reset mid-frame: assert rst_n low during a write data byte -> regs back to RESET_VAL. Continued SCLK pulses with cs_n held low cause no writes until cs_n toggles high then low.
